call_command_responder: RTL and testbench

- Application-layer end of the UI command interface.
- Accepts call-control commands (command + address) from the user interface and runs per-node call state.
- Exchanges call packets with the network layer.
- Returns status to the UI: init done, incoming call, caller address, call active, last result.

---
 rtl/call_command_responder.sv | 170 +++++++++++++++++
 tb/tb_call_command_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/call_command_responder.sv
// call_command_responder: UI call-control endpoint running per-node call state; define CALL_BLOCK_EN to add the BLOCK caller filter
module call_command_responder #(
  parameter int TIMER_W = 24,
  parameter int CALL_TIMEOUT = 10000000,
  parameter logic [7:0] BCAST_ADDR = 8'hFF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] my_addr,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] command,
  input  logic [7:0] address,
  output logic       init,
  output logic       incoming_call,
  output logic [7:0] inc_address,
  output logic       call_active,
  output logic [1:0] status,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [2:0] tx_type,
  output logic [7:0] tx_dest,
  input  logic       rx_valid,
  input  logic [2:0] rx_type,
  input  logic [7:0] rx_src
);
  localparam logic [2:0] C_INIT = 3'd1, C_CALL = 3'd2, C_ACCEPT = 3'd3, C_REJECT = 3'd4, C_END = 3'd5, C_VM = 3'd6;
  localparam logic [2:0] T_INIT = 3'd0, T_REQ = 3'd1, T_ACK = 3'd2, T_NAK = 3'd3, T_HUP = 3'd4;
  localparam logic [1:0] S_NONE = 2'd0, S_OK = 2'd1, S_REJ = 2'd2, S_TMO = 2'd3;

  typedef enum logic [2:0] {UNINIT, IDLE, DIALING, RINGING, CONNECTED} state_t;

  state_t state, state_nx;
  logic [7:0] peer, peer_nx, inc_nx, tx_dest_nx;
  logic [1:0] status_nx;
  logic [2:0] tx_type_nx;
  logic [TIMER_W-1:0] timer;
  logic acc, timing, timeout, rx_peer, busy_req, blocked, tx_go;

  assign cmd_ready = !tx_valid && !rx_valid;
  assign acc = cmd_valid && cmd_ready;
  assign timing = state == DIALING || state == RINGING;
  assign timeout = timing && timer == TIMER_W'(CALL_TIMEOUT - 1);
  assign rx_peer = rx_valid && rx_src == peer;
  assign busy_req = rx_valid && rx_type == T_REQ && rx_src != peer &&
                    (state == DIALING || state == RINGING || state == CONNECTED);
  assign init = state != UNINIT;
  assign incoming_call = state == RINGING;
  assign call_active = state == CONNECTED;

`ifdef CALL_BLOCK_EN
  localparam logic [2:0] C_BLOCK = 3'd7;
  logic [7:0] blocked_addr;
  assign blocked = state == IDLE && rx_valid && rx_type == T_REQ && blocked_addr != 8'h00 && rx_src == blocked_addr;
  // BLOCK reloads the filtered caller address; zero turns filtering off
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) blocked_addr <= 8'h00;
    else if (acc && command == C_BLOCK) blocked_addr <= address;
`else
  assign blocked = 1'b0;
`endif

  // Next call state, result and outgoing packet; received packets outrank timeouts, which outrank commands
  always_comb begin
    state_nx = state;
    peer_nx = peer;
    inc_nx = inc_address;
    status_nx = status;
    tx_go = 1'b0;
    tx_type_nx = tx_type;
    tx_dest_nx = tx_dest;
    case (state)
      UNINIT:
        if (rx_valid && rx_type == T_INIT) state_nx = IDLE;
        else if (acc && command == C_INIT) begin
          state_nx = IDLE;
          tx_go = 1'b1;
          tx_type_nx = T_INIT;
          tx_dest_nx = BCAST_ADDR;
        end
      IDLE:
        if (blocked) begin
          tx_go = 1'b1;
          tx_type_nx = T_NAK;
          tx_dest_nx = rx_src;
        end else if (rx_valid && rx_type == T_REQ) begin
          state_nx = RINGING;
          peer_nx = rx_src;
          inc_nx = rx_src;
        end else if (acc && command == C_CALL) begin
          if (address == my_addr) status_nx = S_REJ;
          else begin
            state_nx = DIALING;
            peer_nx = address;
            status_nx = S_NONE;
            tx_go = 1'b1;
            tx_type_nx = T_REQ;
            tx_dest_nx = address;
          end
        end
      DIALING:
        if (rx_peer && rx_type == T_ACK) begin
          state_nx = CONNECTED;
          status_nx = S_OK;
        end else if (rx_peer && rx_type == T_NAK) begin
          state_nx = IDLE;
          status_nx = S_REJ;
        end else if (timeout || (acc && command == C_END)) begin
          state_nx = IDLE;
          status_nx = timeout ? S_TMO : status;
          tx_go = 1'b1;
          tx_type_nx = T_HUP;
          tx_dest_nx = peer;
        end
      RINGING:
        if (rx_peer && rx_type == T_HUP) state_nx = IDLE;
        else if (timeout || (acc && (command == C_REJECT || command == C_VM))) begin
          state_nx = IDLE;
          status_nx = timeout ? S_TMO : status;
          tx_go = 1'b1;
          tx_type_nx = T_NAK;
          tx_dest_nx = peer;
        end else if (acc && command == C_ACCEPT) begin
          state_nx = CONNECTED;
          status_nx = S_OK;
          tx_go = 1'b1;
          tx_type_nx = T_ACK;
          tx_dest_nx = peer;
        end
      CONNECTED:
        if (rx_peer && rx_type == T_HUP) state_nx = IDLE;
        else if (acc && command == C_END) begin
          state_nx = IDLE;
          tx_go = 1'b1;
          tx_type_nx = T_HUP;
          tx_dest_nx = peer;
        end
      default: state_nx = UNINIT;
    endcase
    if (busy_req && !tx_go) begin
      tx_go = 1'b1;
      tx_type_nx = T_NAK;
      tx_dest_nx = rx_src;
    end
  end

  // State, call registers, timeout timer and the single-entry transmit slot
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= UNINIT;
      peer <= 8'h00;
      inc_address <= 8'h00;
      status <= S_NONE;
      timer <= '0;
      tx_valid <= 1'b0;
      tx_type <= 3'd0;
      tx_dest <= 8'h00;
    end else begin
      state <= state_nx;
      peer <= peer_nx;
      inc_address <= inc_nx;
      status <= status_nx;
      timer <= state_nx != state ? '0 : timing ? timer + TIMER_W'(timer != '1) : timer;
      tx_valid <= tx_valid ? !tx_ready : tx_go;
      if (!tx_valid) begin
        tx_type <= tx_type_nx;
        tx_dest <= tx_dest_nx;
      end
    end
endmodule

// File: tb/tb_call_command_responder.sv
// tb_call_command_responder: directed scenarios checked against a behavioural call model every cycle
module tb_call_command_responder;
  localparam int TO = 16;
  localparam int U = 0, I = 1, D = 2, R = 3, C = 4;
  localparam int T_INIT = 0, T_REQ = 1, T_ACK = 2, T_NAK = 3, T_HUP = 4;
`ifdef CALL_BLOCK_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif

  logic clk = 1'b0, reset_n = 1'b0;
  logic [7:0] my_addr = 8'h05;
  logic cmd_valid = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0;
  logic [2:0] command = 3'd0, rx_type = 3'd0;
  logic [7:0] address = 8'h00, rx_src = 8'h00;
  logic cmd_ready, init, incoming_call, call_active, tx_valid;
  logic [7:0] inc_address, tx_dest;
  logic [1:0] status;
  logic [2:0] tx_type;
  int pass_cnt = 0, total = 0;

  int m_mode = U, m_tmr = 0, m_peer = 0, m_inc = 0, m_blk = 0, m_status = 0, m_ttype = 0, m_tdest = 0;
  bit m_txv = 1'b0;

  always #5 clk = ~clk;

  call_command_responder #(.CALL_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .my_addr(my_addr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .command(command), .address(address),
    .init(init), .incoming_call(incoming_call), .inc_address(inc_address),
    .call_active(call_active), .status(status),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_type(tx_type), .tx_dest(tx_dest),
    .rx_valid(rx_valid), .rx_type(rx_type), .rx_src(rx_src)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Call model: reacts to received packets first, then ring/dial expiry, then an accepted command
  always @(posedge clk or negedge reset_n) begin : model
    int n_mode, n_peer, n_inc, n_status, n_blk, st, sd;
    bit take, fp, busy, snd;
    if (!reset_n) begin
      m_mode <= U; m_tmr <= 0; m_peer <= 0; m_inc <= 0; m_blk <= 0;
      m_status <= 0; m_txv <= 1'b0; m_ttype <= 0; m_tdest <= 0;
    end else begin
      n_mode = m_mode; n_peer = m_peer; n_inc = m_inc; n_status = m_status; n_blk = m_blk;
      snd = 1'b0; st = 0; sd = 0; busy = 1'b0;
      take = cmd_valid && !m_txv && !rx_valid;
      fp = rx_valid && int'(rx_src) == m_peer;
      if (rx_valid) begin
        if (m_mode == U && int'(rx_type) == T_INIT) n_mode = I;
        if (m_mode == I && int'(rx_type) == T_REQ) begin
          if (BLK && m_blk != 0 && int'(rx_src) == m_blk) begin snd = 1'b1; st = T_NAK; sd = int'(rx_src); end
          else begin n_mode = R; n_peer = int'(rx_src); n_inc = int'(rx_src); end
        end
        if (m_mode >= D && int'(rx_type) == T_REQ && !fp) busy = 1'b1;
        if (fp && m_mode == D && int'(rx_type) == T_ACK) begin n_mode = C; n_status = 1; end
        if (fp && m_mode == D && int'(rx_type) == T_NAK) begin n_mode = I; n_status = 2; end
        if (fp && (m_mode == R || m_mode == C) && int'(rx_type) == T_HUP) n_mode = I;
      end
      if (n_mode == m_mode && (m_mode == D || m_mode == R) && m_tmr == TO - 1) begin
        n_mode = I; n_status = 3; snd = 1'b1; st = (m_mode == D) ? T_HUP : T_NAK; sd = m_peer;
      end else if (take) begin
        if (int'(command) == 1 && m_mode == U) begin n_mode = I; snd = 1'b1; st = T_INIT; sd = 'hFF; end
        if (int'(command) == 2 && m_mode == I) begin
          if (address == my_addr) n_status = 2;
          else begin n_mode = D; n_peer = int'(address); n_status = 0; snd = 1'b1; st = T_REQ; sd = int'(address); end
        end
        if (int'(command) == 3 && m_mode == R) begin n_mode = C; n_status = 1; snd = 1'b1; st = T_ACK; sd = m_peer; end
        if ((int'(command) == 4 || int'(command) == 6) && m_mode == R) begin n_mode = I; snd = 1'b1; st = T_NAK; sd = m_peer; end
        if (int'(command) == 5 && (m_mode == D || m_mode == C)) begin n_mode = I; snd = 1'b1; st = T_HUP; sd = m_peer; end
        if (int'(command) == 7 && BLK) n_blk = int'(address);
      end
      if (busy && !snd) begin snd = 1'b1; st = T_NAK; sd = int'(rx_src); end
      m_mode <= n_mode; m_peer <= n_peer; m_inc <= n_inc; m_status <= n_status; m_blk <= n_blk;
      m_tmr <= (n_mode != m_mode) ? 0 : (m_mode == D || m_mode == R) ? m_tmr + 1 : m_tmr;
      if (m_txv) m_txv <= !tx_ready;
      else if (snd) begin m_txv <= 1'b1; m_ttype <= st; m_tdest <= sd; end
    end
  end

  // Every cycle the DUT outputs must agree with the model
  always @(negedge clk) begin
    chk("m_init", 32'(init), 32'(m_mode != U));
    chk("m_incoming", 32'(incoming_call), 32'(m_mode == R));
    chk("m_call_active", 32'(call_active), 32'(m_mode == C));
    chk("m_inc_address", 32'(inc_address), m_inc);
    chk("m_status", 32'(status), m_status);
    chk("m_tx_valid", 32'(tx_valid), 32'(m_txv));
    chk("m_cmd_ready", 32'(cmd_ready), 32'(!m_txv && !rx_valid));
    if (m_txv) begin
      chk("m_tx_type", 32'(tx_type), m_ttype);
      chk("m_tx_dest", 32'(tx_dest), m_tdest);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [2:0] c, input logic [7:0] a);
    bit ok = 1'b0;
    cmd_valid = 1'b1; command = c; address = a;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    chk("cmd_accepted", 32'(ok), 1);
  endtask

  task automatic rx_pkt(input logic [2:0] t, input logic [7:0] s);
    rx_valid = 1'b1; rx_type = t; rx_src = s;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  initial begin
    cyc(2);
    chk("rst_init", 32'(init), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_status", 32'(status), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    reset_n = 1'b1;
    cyc(1);
    do_cmd(3'd1, 8'h00);
    chk("init_tx_valid", 32'(tx_valid), 1);
    chk("init_tx_type", 32'(tx_type), 0);
    chk("init_tx_dest", 32'(tx_dest), 'hFF);
    chk("init_flag", 32'(init), 1);
    chk("init_cmd_ready", 32'(cmd_ready), 0);
    cyc(2);
    chk("init_tx_held", 32'(tx_valid), 1);
    tx_ready = 1'b1;
    cyc(1);
    chk("init_tx_done", 32'(tx_valid), 0);
    do_cmd(3'd2, 8'h0A);
    chk("call_tx_type", 32'(tx_type), 1);
    chk("call_tx_dest", 32'(tx_dest), 'h0A);
    cyc(1);
    rx_pkt(3'd2, 8'h0A);
    chk("ack_call_active", 32'(call_active), 1);
    chk("ack_status", 32'(status), 1);
    tx_ready = 1'b0;
    do_cmd(3'd5, 8'h00);
    chk("end_tx_type", 32'(tx_type), 4);
    chk("end_tx_dest", 32'(tx_dest), 'h0A);
    chk("end_call_active", 32'(call_active), 0);
    cyc(2);
    chk("end_cmd_ready_low", 32'(cmd_ready), 0);
    tx_ready = 1'b1;
    cyc(1);
    chk("end_cmd_ready_back", 32'(cmd_ready), 1);
    rx_pkt(3'd1, 8'h21);
    chk("ring_incoming", 32'(incoming_call), 1);
    chk("ring_inc_address", 32'(inc_address), 'h21);
    do_cmd(3'd3, 8'h00);
    chk("accept_tx_type", 32'(tx_type), 2);
    chk("accept_tx_dest", 32'(tx_dest), 'h21);
    chk("accept_call_active", 32'(call_active), 1);
    chk("accept_incoming", 32'(incoming_call), 0);
    cyc(1);
    rx_pkt(3'd4, 8'h21);
    chk("hup_call_active", 32'(call_active), 0);
    do_cmd(3'd2, 8'h05);
    chk("self_call_status", 32'(status), 2);
    chk("self_call_no_tx", 32'(tx_valid), 0);
    do_cmd(3'd2, 8'h0A);
    chk("dial_status_none", 32'(status), 0);
    rx_pkt(3'd2, 8'h0B);
    chk("foreign_ack_ignored", 32'(call_active), 0);
    cyc(TO - 2);
    chk("dial_pre_timeout_tx", 32'(tx_valid), 0);
    chk("dial_pre_timeout_status", 32'(status), 0);
    cyc(1);
    chk("timeout_tx_valid", 32'(tx_valid), 1);
    chk("timeout_tx_type", 32'(tx_type), 4);
    chk("timeout_tx_dest", 32'(tx_dest), 'h0A);
    chk("timeout_status", 32'(status), 3);
    cyc(1);
    do_cmd(3'd2, 8'h0A);
    cyc(1);
    rx_pkt(3'd2, 8'h0A);
    chk("busy_connected", 32'(call_active), 1);
    rx_valid = 1'b1; rx_type = 3'd1; rx_src = 8'h33;
    cmd_valid = 1'b1; command = 3'd5;
    @(negedge clk);
    chk("prio_cmd_ready", 32'(cmd_ready), 0);
    @(posedge clk);
    #1;
    rx_valid = 1'b0; cmd_valid = 1'b0;
    chk("busy_tx_type", 32'(tx_type), 3);
    chk("busy_tx_dest", 32'(tx_dest), 'h33);
    chk("busy_call_active", 32'(call_active), 1);
    cyc(1);
    chk("busy_cmd_dropped", 32'(call_active), 1);
    do_cmd(3'd5, 8'h00);
    chk("busy_end_dest", 32'(tx_dest), 'h0A);
    cyc(1);
    rx_pkt(3'd1, 8'h21);
    chk("ring2_incoming", 32'(incoming_call), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_init", 32'(init), 0);
    chk("arst_incoming", 32'(incoming_call), 0);
    chk("arst_inc_address", 32'(inc_address), 0);
    chk("arst_call_active", 32'(call_active), 0);
    chk("arst_status", 32'(status), 0);
    chk("arst_tx_valid", 32'(tx_valid), 0);
    chk("arst_tx_dest", 32'(tx_dest), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rx_pkt(3'd0, 8'h99);
    chk("rx_init_flag", 32'(init), 1);
    chk("rx_init_no_tx", 32'(tx_valid), 0);
    do_cmd(3'd7, 8'h44);
    rx_pkt(3'd1, 8'h44);
`ifdef CALL_BLOCK_EN
    chk("blk_incoming", 32'(incoming_call), 0);
    chk("blk_tx_type", 32'(tx_type), 3);
    chk("blk_tx_dest", 32'(tx_dest), 'h44);
    chk("blk_inc_address", 32'(inc_address), 0);
    cyc(1);
    do_cmd(3'd7, 8'h00);
    rx_pkt(3'd1, 8'h44);
    chk("unblk_incoming", 32'(incoming_call), 1);
`else
    chk("noblk_incoming", 32'(incoming_call), 1);
    chk("noblk_inc_address", 32'(inc_address), 'h44);
    chk("noblk_no_tx", 32'(tx_valid), 0);
`endif
    cyc(2);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
